router_src_arbiter: RTL

Round-robin input arbiter that shares the router's single byte-wide input port (`packet_valid`/`datain`, back-pressured by `busy`) between three packet sources. It grants one source at a time and holds the grant for a whole packet: header, payload, then the parity byte. Between grants it re-arbitrates. It sits directly in front of the router input.

---
 rtl/router_src_arbiter_if.sv | 23 ++
 rtl/router_src_arbiter.sv | 82 ++++++++
 2 files changed

// File: rtl/router_src_arbiter_if.sv
// router_src_arbiter_if: source-side request/data/grant lines and router-side
// packet_valid/datain/busy handshake shared by router_src_arbiter.
interface router_src_arbiter_if #(
  parameter int N_SRC  = 3,
  parameter int DATA_W = 8
);
  logic [N_SRC-1:0]        src_req;
  logic [N_SRC-1:0]        src_pkt_valid;
  logic [N_SRC*DATA_W-1:0] src_data;
  logic [N_SRC-1:0]        src_gnt;
  logic [N_SRC-1:0]        src_stall;
  logic                    busy;
  logic                    packet_valid;
  logic [DATA_W-1:0]       datain;
  modport master (
    output src_req, src_pkt_valid, src_data, busy,
    input  src_gnt, src_stall, packet_valid, datain
  );
  modport slave (
    input  src_req, src_pkt_valid, src_data, busy,
    output src_gnt, src_stall, packet_valid, datain
  );
endinterface

// File: rtl/router_src_arbiter.sv
// router_src_arbiter: round-robin, packet-locked arbiter sharing the router input among three sources.
// Define ROUTER_ARB_LEN_CHECK_EN to build the header-length vs payload-count check driving len_err.
module router_src_arbiter (
  input  logic                 clk,
  input  logic                 reset,
  router_src_arbiter_if.slave  bus,
  output logic                 arb_idle,
  output logic                 len_err
);
  typedef enum logic [1:0] {IDLE, XFER, DONE} state_e;
  state_e     state_q;
  logic [2:0] gnt_q;
  logic [1:0] last_q;
  logic       hdr_seen_q;
  logic [1:0] c1, c2, win;
  logic       any_req, accept, pv_mux, xfer;
  logic [7:0] byte_mux;
  always_comb begin
    c1       = last_q == 2'd2 ? 2'd0 : last_q + 2'd1;
    c2       = last_q == 2'd0 ? 2'd2 : last_q - 2'd1;
    win      = bus.src_req[c1] ? c1 : bus.src_req[c2] ? c2 : last_q;
    any_req  = |bus.src_req;
    accept   = !bus.busy;
    xfer     = state_q == XFER;
    pv_mux   = |(gnt_q & bus.src_pkt_valid);
    byte_mux = ({8{gnt_q[0]}} & bus.src_data[7:0])
             | ({8{gnt_q[1]}} & bus.src_data[15:8])
             | ({8{gnt_q[2]}} & bus.src_data[23:16]);
  end
  assign bus.src_gnt      = gnt_q;
  assign bus.src_stall    = gnt_q & {3{bus.busy}};
  assign bus.packet_valid = xfer & pv_mux;
  assign bus.datain       = xfer ? byte_mux : 8'd0;
  assign arb_idle         = state_q == IDLE;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      gnt_q      <= 3'b000;
      last_q     <= 2'd2;
      hdr_seen_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (accept && any_req) begin
          state_q    <= XFER;
          gnt_q      <= 3'b001 << win;
          last_q     <= win;
          hdr_seen_q <= 1'b0;
        end
        XFER: if (accept) begin
          if (pv_mux) hdr_seen_q <= 1'b1;
          else if (hdr_seen_q) begin
            state_q <= DONE;
            gnt_q   <= 3'b000;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
`ifdef ROUTER_ARB_LEN_CHECK_EN
  logic [5:0] hdr_len_q, pay_cnt_q;
  logic       len_err_q, xfer_acc;
  assign xfer_acc = xfer & accept;
  // len_err_q is rewritten every edge, so the mismatch shows for exactly one cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      hdr_len_q <= 6'd0;
      pay_cnt_q <= 6'd0;
      len_err_q <= 1'b0;
    end else begin
      len_err_q <= xfer_acc && !pv_mux && hdr_seen_q && pay_cnt_q != hdr_len_q;
      if (xfer_acc && pv_mux) begin
        hdr_len_q <= hdr_seen_q ? hdr_len_q : byte_mux[7:2];
        pay_cnt_q <= hdr_seen_q ? pay_cnt_q + 6'd1 : 6'd0;
      end
    end
  end
  assign len_err = len_err_q;
`else
  assign len_err = 1'b0;
`endif
endmodule
